// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier error-metric blocks:
// run-control state encoding and the default operand/derived widths.
package approx_mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int PW        = 2 * DEF_WIDTH;      // product / error-distance width
  localparam int SW        = 4 * DEF_WIDTH;      // error-distance sum width
  localparam int CW        = 2 * DEF_WIDTH + 1;  // sample / error counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/approx_mult_err_monitor_abs_diff.sv
// Unsigned absolute difference and inequality flag of two registered values,
// built from compare-and-subtract so no signed arithmetic is needed.
module abs_diff #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic [W-1:0] o_diff,
  output logic         o_neq
);

  assign o_diff = (i_x >= i_y) ? (i_x - i_y) : (i_y - i_x);
  assign o_neq  = (i_x != i_y);

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Error-metric accumulator behind the approximate multiplier: recomputes the
// exact product and gathers error count, max and sum of error distance per run.
module approx_mult_err_monitor
  import approx_mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SAMPLES = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2*WIDTH-1:0]   in_apprx,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   max_ed,
  output logic [4*WIDTH-1:0]   sum_ed,
  output logic [2*WIDTH:0]     sample_count
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int SUM_W  = 4 * WIDTH;
  localparam int CNT_W  = 2 * WIDTH + 1;

  localparam logic [CNT_W-1:0] SAMPLES_C = CNT_W'(SAMPLES);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SAMPLES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_clear;
  logic [CNT_W-1:0]   r_accepted;

  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [PROD_W-1:0]  r_s1_apprx;

  logic [PROD_W-1:0]  w_exact;
  logic [PROD_W-1:0]  w_ed;
  logic               w_neq;

  logic               r_s2_valid;
  logic [PROD_W-1:0]  r_s2_ed;
  logic               r_s2_neq;

  logic [CNT_W-1:0]   r_err_count;
  logic [PROD_W-1:0]  r_max_ed;
  logic [SUM_W-1:0]   r_sum_ed;
  logic [CNT_W-1:0]   r_sample_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = (r_accepted < SAMPLES_C);
        if (in_valid && in_ready && (r_accepted == LAST_IDX)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // S1 empty now means the last sample leaves S2 on this edge.
        if (!r_s1_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
    end
  end

  // NOTE: pipeline data registers carry no reset; the valid bits alone
  // qualify them, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_apprx <= in_apprx;
    end
    r_s2_ed  <= w_ed;
    r_s2_neq <= w_neq;
  end

  assign w_exact = {{WIDTH{1'b0}}, r_s1_a} * {{WIDTH{1'b0}}, r_s1_b};

  abs_diff #(.W(PROD_W)) u_abs_diff (
    .i_x    (w_exact),
    .i_y    (r_s1_apprx),
    .o_diff (w_ed),
    .o_neq  (w_neq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_accepted     <= '0;
      r_err_count    <= '0;
      r_max_ed       <= '0;
      r_sum_ed       <= '0;
      r_sample_count <= '0;
    end else begin
      if (w_accept) r_accepted <= r_accepted + CNT_W'(1);
      if (r_s2_valid) begin
        r_sum_ed       <= r_sum_ed + SUM_W'(r_s2_ed);
        r_err_count    <= r_err_count + CNT_W'(r_s2_neq);
        r_sample_count <= r_sample_count + CNT_W'(1);
        if (r_s2_ed > r_max_ed) r_max_ed <= r_s2_ed;
      end
    end
  end

  assign err_count    = r_err_count;
  assign max_ed       = r_max_ed;
  assign sum_ed       = r_sum_ed;
  assign sample_count = r_sample_count;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Self-checking bench: directed and randomized runs on a 4-sample monitor,
// plus an exhaustive exact-product run on a default-sized monitor.
module tb_approx_mult_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: SAMPLES=4
  logic        a_start, a_valid, a_ready, a_busy, a_done;
  logic [7:0]  a_in_a, a_in_b;
  logic [15:0] a_apprx, a_max;
  logic [16:0] a_err, a_cnt;
  logic [31:0] a_sum;

  // Instance B: default parameters
  logic        b_start, b_valid, b_ready, b_busy, b_done;
  logic [7:0]  b_in_a, b_in_b;
  logic [15:0] b_apprx, b_max;
  logic [16:0] b_err, b_cnt;
  logic [31:0] b_sum;

  approx_mult_err_monitor #(.WIDTH(8), .SAMPLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
    .in_a(a_in_a), .in_b(a_in_b), .in_apprx(a_apprx), .busy(a_busy), .done(a_done),
    .err_count(a_err), .max_ed(a_max), .sum_ed(a_sum), .sample_count(a_cnt)
  );

  approx_mult_err_monitor dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_apprx(b_apprx), .busy(b_busy), .done(b_done),
    .err_count(b_err), .max_ed(b_max), .sum_ed(b_sum), .sample_count(b_cnt)
  );

  typedef struct {
    int a;
    int b;
    int apprx;
  } sample_t;

  sample_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int a, input int b, input int apprx);
    sample_t s;
    s.a = a; s.b = b; s.apprx = apprx;
    q.push_back(s);
  endtask

  // Reference metrics straight from the definitions over the whole run.
  task automatic model(output longint e, output longint m, output longint s);
    e = 0; m = 0; s = 0;
    foreach (q[i]) begin
      longint d;
      d = longint'(q[i].a) * q[i].b - q[i].apprx;
      if (d < 0) d = -d;
      if (d != 0) e++;
      if (d > m) m = d;
      s += d;
    end
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input bit gaps, input bit mid_start);
    for (int i = first; i <= last; i++) begin
      int g;
      a_in_a  = 8'(q[i].a);
      a_in_b  = 8'(q[i].b);
      a_apprx = 16'(q[i].apprx);
      a_valid = 1'b1;
      g = 0;
      while (!a_ready && g < 50) begin
        tick();
        g++;
      end
      if (!a_ready) check("ready_timeout", a_ready, 1);
      tick();
      a_valid = 1'b0;
      a_in_a  = 8'($urandom);
      a_in_b  = 8'($urandom);
      a_apprx = 16'($urandom);
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      if (mid_start && i == 1) start_a();
    end
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!a_done && g < 50) begin
      tick();
      g++;
    end
    check("done", a_done, 1);
  endtask

  task automatic check_results(input string tag);
    longint e, m, s;
    model(e, m, s);
    check({tag, "_err"}, a_err, e);
    check({tag, "_max"}, a_max, m);
    check({tag, "_sum"}, a_sum, s);
    check({tag, "_cnt"}, a_cnt, q.size());
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_ready"}, a_ready, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, a_ready, 0);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_err"}, a_err, 0);
    check({tag, "_max"}, a_max, 0);
    check({tag, "_sum"}, a_sum, 0);
    check({tag, "_cnt"}, a_cnt, 0);
  endtask

  task automatic load_err_set();
    q.delete();
    add(255, 255, 65000);
    add(2, 3, 8);
    add(12, 12, 144);
    add(1, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_valid = 0; a_in_a = 0; a_in_b = 0; a_apprx = 0;
    b_start = 0; b_valid = 0; b_in_a = 0; b_in_b = 0; b_apprx = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_cleared("reset");

    // Exact products only
    q.delete();
    add(3, 5, 15); add(255, 255, 65025); add(0, 7, 0); add(10, 10, 100);
    start_a();
    feed(0, 3, 0, 0);
    wait_done();
    check_results("exact");

    // Errors in both directions, hand-derived totals
    load_err_set();
    start_a();
    feed(0, 3, 0, 0);
    wait_done();
    check_results("errs");
    check("errs_err_k", a_err, 3);
    check("errs_max_k", a_max, 25);
    check("errs_sum_k", a_sum, 28);

    // in_valid while DONE is ignored
    a_valid = 1'b1;
    repeat (3) begin
      tick();
      check("done_ready", a_ready, 0);
    end
    a_valid = 1'b0;
    check("done_cnt", a_cnt, 4);

    // in_valid while IDLE is ignored, then a gapped run
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    a_valid = 1'b1;
    repeat (3) begin
      tick();
      check("idle_ready", a_ready, 0);
    end
    a_valid = 1'b0;
    check("idle_cnt", a_cnt, 0);
    start_a();
    feed(0, 3, 1, 0);
    wait_done();
    check_results("gaps");

    // Reset mid-run aborts and clears
    start_a();
    feed(0, 1, 0, 0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_cleared("abort");
    start_a();
    feed(0, 3, 0, 0);
    wait_done();
    check_results("rerun");

    // start in RUN ignored; start in DONE restarts with a clear
    start_a();
    feed(0, 3, 1, 1);
    wait_done();
    check_results("midstart");
    start_a();
    check("restart_err", a_err, 0);
    check("restart_sum", a_sum, 0);
    check("restart_cnt", a_cnt, 0);
    check("restart_busy", a_busy, 1);
    check("restart_done", a_done, 0);
    a_in_a = 8'(q[0].a); a_in_b = 8'(q[0].b); a_apprx = 16'(q[0].apprx);
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    check("lat_edge0", a_cnt, 0);
    tick();
    check("lat_edge1", a_cnt, 0);
    tick();
    check("lat_edge2", a_cnt, 1);
    feed(1, 3, 0, 0);
    wait_done();
    check_results("restart");

    // Randomized runs
    for (int r = 0; r < 15; r++) begin
      q.delete();
      for (int k = 0; k < 4; k++) begin
        int a, b, ex, ap;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        if ($urandom_range(0, 4) == 0) a = 255;
        if ($urandom_range(0, 4) == 0) b = 0;
        ex = a * b;
        case ($urandom_range(0, 3))
          0: ap = ex;
          1: ap = (ex + $urandom_range(1, 300) > 65535) ? 65535 : ex + $urandom_range(1, 300);
          2: ap = (ex < 300) ? 0 : ex - $urandom_range(1, 300);
          default: ap = $urandom_range(0, 65535);
        endcase
        add(a, b, ap);
      end
      start_a();
      feed(0, 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done();
      check_results("rand");
    end

    // Exhaustive exact-product run on the default-sized monitor
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        int g;
        b_in_a  = 8'(a);
        b_in_b  = 8'(b);
        b_apprx = 16'(a * b);
        b_valid = 1'b1;
        g = 0;
        while (!b_ready && g < 10) begin
          tick();
          g++;
        end
        tick();
      end
    end
    b_valid = 1'b0;
    begin
      int g;
      g = 0;
      while (!b_done && g < 20) begin
        tick();
        g++;
      end
    end
    check("exh_done", b_done, 1);
    check("exh_cnt", b_cnt, 65536);
    check("exh_err", b_err, 0);
    check("exh_sum", b_sum, 0);
    check("exh_max", b_max, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/approx_mult_err_monitor.md
Name: approx_mult_err_monitor

Overview:
- Hardware error-metric accumulator placed directly downstream of the 8-bit approximate Dadda multiplier.
- Accepts one (A, B, approximate product) sample per handshake and computes the exact product internally.
- Accumulates error count, maximum error distance and sum of error distances over a fixed sample run.
- Software derives MED, NED and AOC from the results: MED = sum_ed >> 16 at default, AOC = SAMPLES - err_count.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- SAMPLES, 65536, samples per run; range 1..2^(2*WIDTH).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; clears accumulators and begins a run.
- in_valid  input  1  sample valid.
- in_ready  output  1  monitor can accept a sample.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_apprx  input  2*WIDTH  approximate product from the multiplier under test.
- busy  output  1  run in progress (RUN or DRAIN).
- done  output  1  results final; held until the next start or reset.
- err_count  output  2*WIDTH+1  number of samples with apprx != exact.
- max_ed  output  2*WIDTH  largest |exact - apprx|.
- sum_ed  output  4*WIDTH  sum of |exact - apprx|.
- sample_count  output  2*WIDTH+1  samples accumulated so far.

Behaviour:
- Reset (synchronous, rst_n=0 at an edge):
  - State goes to IDLE.
  - Pipeline valids are cleared.
  - All outputs are 0: in_ready, busy, done, err_count, max_ed, sum_ed, sample_count.
  - Reset during RUN or DRAIN aborts the run; partial results are discarded.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN. Accumulators, sample_count and the accepted count are cleared on the same edge.
  - RUN: in_ready=1 while accepted < SAMPLES. When the SAMPLES-th sample is accepted -> DRAIN, and in_ready drops the next cycle.
  - DRAIN: held until both pipeline stages are empty (2 cycles after the last accept) -> DONE.
  - DONE: done=1 and outputs are frozen. start -> RUN with a clear, identical to IDLE.
  - start in RUN or DRAIN is ignored.
- Handshake:
  - A sample is accepted on an edge where in_valid && in_ready.
  - in_valid while in_ready=0 has no effect.
  - Gaps in in_valid are allowed and do not stall results.
- Pipeline (no backpressure inside; always advances):
  - S1: register a, b, apprx and a valid bit.
  - S2: exact = a*b (2*WIDTH, unsigned); ed = |exact - apprx| via compare-and-subtract, no signed arithmetic; register ed, a neq flag and a valid bit.
  - Accumulate: when the S2 valid bit is set:
    - sum_ed += ed
    - err_count += neq
    - max_ed = max(max_ed, ed)
    - sample_count += 1
  - Latency: accept edge -> accumulator outputs updated 2 edges later.
- Width rules:
  - sum_ed cannot overflow: max 2^(2W) * (2^(2W) - 1) < 2^(4W).
  - err_count and sample_count reach SAMPLES exactly (17 bits at default).
- Boundaries:
  - SAMPLES=1: RUN lasts exactly one accepted sample.
  - ed=0 never updates max_ed.
  - apprx > exact is handled symmetrically with apprx < exact.
  - Operands 0 or all-ones are legal.
- busy = (state==RUN) || (state==DRAIN).
- done = (state==DONE).

Decomposition:
- Shared package approx_mult_pkg holds:
  - state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
  - WIDTH default
  - derived width constants: PW=2*WIDTH, SW=4*WIDTH, CW=2*WIDTH+1
- One sub-module, abs_diff, computes the registered-input absolute difference and the neq flag. It is reused by future error-metric blocks.
- The exact multiplier stays behavioural (a*b) inside the monitor.

Test Plan:
- SAMPLES=4; samples (3,5,15), (255,255,65025), (0,7,0), (10,10,100) -> done after DRAIN; err_count=0, max_ed=0, sum_ed=0, sample_count=4.
- SAMPLES=4; samples (255,255,65000), (2,3,8), (12,12,144), (1,1,0) -> err_count=3, max_ed=25, sum_ed=28.
- Same samples as the previous scenario with random in_valid gaps, plus in_valid asserted in IDLE and DONE -> identical results; in_ready=0 outside RUN; no extra samples counted.
- rst_n=0 for one cycle after 2 accepts in RUN -> next cycle all outputs 0 and state IDLE. A new start with the previous-scenario samples gives err_count=3, sum_ed=28.
- start pulsed during RUN -> ignored, results unchanged. start in DONE -> outputs cleared the next cycle, busy=1, and a new run completes correctly.
- Default parameters, exhaustive 0..255 x 0..255 with apprx=a*b -> sample_count=65536, err_count=0, sum_ed=0, done=1.
